// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MFHI/MFLO/MTHI/MTLO.
// Operations take WIDTH iteration cycles plus one fix-up cycle; the issue handshake is valid/ready.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;
    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;

    // Working registers: acc is product-high / partial remainder, sr is multiplier / quotient,
    // opnd is multiplicand / divisor. They are only meaningful between accept and FIX.
    logic [WIDTH-1:0]   acc_q, acc_d, sr_q, sr_d, opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;

    logic               accept;
    logic               sgn_a, sgn_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && (state_q == S_IDLE);

    assign sgn_a     = ~op[0] & a[WIDTH-1];
    assign sgn_b     = ~op[0] & b[WIDTH-1];

    assign mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
    assign mul_next  = sr_q[0] ? mul_sum : {1'b0, acc_q};
    // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
    assign div_shift = {acc_q, sr_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    assign prod_fix  = cond_neg2(neg_res_q, {acc_q, sr_q});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        acc_d       = acc_q;
        sr_d        = sr_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MFHI: begin
                            out_valid_d = 1'b1;
                            out_data_d  = hi_q;
                        end
                        OP_MFLO: begin
                            out_valid_d = 1'b1;
                            out_data_d  = lo_q;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: begin
                            state_d   = S_ITER;
                            cnt_d     = '0;
                            acc_d     = '0;
                            is_div_d  = op[1];
                            neg_res_d = sgn_a ^ sgn_b;
                            neg_rem_d = sgn_a;
                            dz_d      = (b == '0);
                            if (op[1]) begin
                                sr_d   = cond_neg(sgn_a, a);
                                opnd_d = cond_neg(sgn_b, b);
                            end else begin
                                sr_d   = cond_neg(sgn_b, b);
                                opnd_d = cond_neg(sgn_a, a);
                            end
                        end
                    endcase
                end
            end
            S_ITER: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_next[WIDTH:1];
                    sr_d  = {mul_next[0], sr_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : cond_neg(neg_res_q, sr_q);
                    hi_d = cond_neg(neg_rem_q, acc_q);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        sr_q      <= sr_d;
        opnd_q    <= opnd_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed literal cases plus randomized ops against an arithmetic model.
module tb_alu_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, done, busy;
    logic [W-1:0] out_data, hi, lo;

    alu_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_data(out_data),
        .done(done), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ov_count = 0;
    int done_count = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi,lo} of a MULT*/DIV* from plain 64-bit arithmetic.
    function automatic logic [63:0] predict(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, r;
        longint unsigned ux, uy, pu, ru;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; return p; end
            3'd1: begin pu = ux * uy; return pu; end
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                p = sx / sy;
                r = sx % sy;
                return {r[31:0], p[31:0]};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                pu = ux / uy;
                ru = ux % uy;
                return {ru[31:0], pu[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    int           m_busy = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_od = '0;
    logic [63:0]  p_res = '0;
    bit           m_ov = 1'b0, m_done = 1'b0, acc_seen = 1'b0;

    // Reference timeline: a MULT*/DIV* accepted at one edge commits WIDTH+1 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_od     <= '0;
            m_ov     <= 1'b0;
            m_done   <= 1'b0;
            acc_seen <= 1'b0;
        end else begin
            m_ov     <= 1'b0;
            m_done   <= 1'b0;
            acc_seen <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_hi   <= p_res[63:32];
                    m_lo   <= p_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (in_valid) begin
                acc_seen <= 1'b1;
                case (op)
                    3'd4: begin m_ov <= 1'b1; m_od <= m_hi; end
                    3'd5: begin m_ov <= 1'b1; m_od <= m_lo; end
                    3'd6: m_hi <= a;
                    3'd7: m_lo <= a;
                    default: begin
                        p_res  <= predict(op, a, b);
                        m_busy <= W + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_busy == 0)});
            chk("busy", {31'd0, busy}, {31'd0, (m_busy != 0)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) chk("out_data", out_data, m_od);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (out_valid === 1'b1) ov_count++;
            if (done === 1'b1) done_count++;
        end
    end

    // Called at a falling edge; holds the request until the model reports acceptance.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_seen) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=none required=accept op=%0d", o);
        end
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, snap;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(n);
        chk("mult_latency", n, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(n);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(n);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'd7, 32'd2);
        wait_done(n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(3'd3, 32'd7, 32'd0);
        wait_done(n);
        chk("divz_latency", n, 32'd33);
        chk("divz_hi", hi, 32'h0000_0007);
        chk("divz_lo", lo, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_latency", n, 32'd33);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0000_0000);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        chk("mfhi_stalled", {31'd0, in_ready}, 32'd0);
        snap = ov_count;
        issue(3'd4, 32'd0, 32'd0);
        chk("mfhi_ov", {31'd0, out_valid}, 32'd1);
        chk("mfhi_data", out_data, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        chk("mfhi_once", ov_count - snap, 32'd1);

        issue(3'd7, 32'h1234_5678, 32'd0);
        issue(3'd5, 32'd0, 32'd0);
        chk("mflo_ov", {31'd0, out_valid}, 32'd1);
        chk("mflo_data", out_data, 32'h1234_5678);

        issue(3'd2, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        snap = done_count;
        repeat (40) @(negedge clk);
        chk("arst_no_done", done_count - snap, 32'd0);

        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
